mul_share_arbiter: RTL and testbench

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

---
 rtl/mul_share_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Two-requester arbiter sharing a single 16x16 unsigned multiplier, one transaction in flight.
// Define MUL_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

module multiplier_16_bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [31:0] product_o
);
    assign product_o = 32'(a_i) * 32'(b_i);
endmodule

module mul_share_arbiter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               res0_valid,
    output logic [2*WIDTH-1:0] res0_data,
    input  logic               res0_ready,
    output logic               res1_valid,
    output logic [2*WIDTH-1:0] res1_data,
    input  logic               res1_ready,
    output logic               busy,
    output logic               gnt_id
);

    typedef enum logic [1:0] {StIdle, StMul, StResp} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               gnt_q, gnt_d;
    logic               res0_valid_q, res0_valid_d;
    logic               res1_valid_q, res1_valid_d;
    logic [31:0]        product;
    logic               grant_sel;
    logic               accept0, accept1;

    multiplier_16_bit u_mul (
        .a_i       (a_q),
        .b_i       (b_q),
        .product_o (product)
    );

`ifdef MUL_RR_EN
    logic last_grant_q, last_grant_d;

    // On contention the requester not served last wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = ~req0_valid;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept0 || accept1) begin
            last_grant_d = accept1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        grant_sel = ~req0_valid;
    end
`endif

    always_comb begin
        accept0 = (state_q == StIdle) && req0_valid && !grant_sel;
        accept1 = (state_q == StIdle) && req1_valid && grant_sel;
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        gnt_d        = gnt_q;
        res_d        = res_q;
        res0_valid_d = res0_valid_q;
        res1_valid_d = res1_valid_q;
        case (state_q)
            StIdle: begin
                if (accept0 || accept1) begin
                    a_d     = accept1 ? req1_a : req0_a;
                    b_d     = accept1 ? req1_b : req0_b;
                    gnt_d   = accept1;
                    state_d = StMul;
                end
            end
            StMul: begin
                res_d        = product;
                res0_valid_d = !gnt_q;
                res1_valid_d = gnt_q;
                state_d      = StResp;
            end
            StResp: begin
                // Only the owner's ready completes the handshake.
                if (gnt_q ? res1_ready : res0_ready) begin
                    res0_valid_d = 1'b0;
                    res1_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d      = StIdle;
                res0_valid_d = 1'b0;
                res1_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            gnt_q        <= 1'b0;
            res_q        <= '0;
            res0_valid_q <= 1'b0;
            res1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            gnt_q        <= gnt_d;
            res_q        <= res_d;
            res0_valid_q <= res0_valid_d;
            res1_valid_q <= res1_valid_d;
        end
    end

    always_comb begin
        req0_ready = accept0;
        req1_ready = accept1;
        res0_valid = res0_valid_q;
        res1_valid = res1_valid_q;
        res0_data  = gnt_q ? '0 : res_q;
        res1_data  = gnt_q ? res_q : '0;
        busy       = (state_q != StIdle);
        gnt_id     = gnt_q;
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed, table-driven self-checking bench for mul_share_arbiter.

module tb_mul_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        res0_valid, res1_valid;
    logic [31:0] res0_data, res1_data;
    logic        res0_ready, res1_ready;
    logic        busy, gnt_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res0_valid (res0_valid),
        .res0_data  (res0_data),
        .res0_ready (res0_ready),
        .res1_valid (res1_valid),
        .res1_data  (res1_data),
        .res1_ready (res1_ready),
        .busy       (busy),
        .gnt_id     (gnt_id)
    );

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transaction with the owner's res ready held high: accept, MUL, RESP, back to IDLE.
    task automatic do_txn(input logic id, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
        res0_ready = 1'b1;
        res1_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req0_valid = 1'b0;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req1_valid = 1'b0;
        end
        #1;
        check("ready_owner", {31'b0, id ? req1_ready : req0_ready}, 32'd1);
        check("ready_other", {31'b0, id ? req0_ready : req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("mul_busy", {31'b0, busy}, 32'd1);
        check("mul_gnt", {31'b0, gnt_id}, {31'b0, id});
        check("mul_no_valid", {30'b0, res1_valid, res0_valid}, 32'd0);
        tick();
        check("resp_valid", {30'b0, res1_valid, res0_valid}, id ? 32'd2 : 32'd1);
        check("resp_data", id ? res1_data : res0_data, exp);
        check("resp_ready_low", {30'b0, req1_ready, req0_ready}, 32'd0);
        tick();
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_valid", {30'b0, res1_valid, res0_valid}, 32'd0);
        check("idle_gnt_hold", {31'b0, gnt_id}, {31'b0, id});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_id;

        vecs[0] = '{1'b0, 16'd12,    16'd10,    32'd120};
        vecs[1] = '{1'b1, 16'hFFFF,  16'hFFFF,  32'hFFFE0001};
        vecs[2] = '{1'b0, 16'd0,     16'd777,   32'd0};
        vecs[3] = '{1'b1, 16'd1,     16'hFFFF,  32'd65535};
        vecs[4] = '{1'b0, 16'hFFFF,  16'd2,     32'd131070};
        vecs[5] = '{1'b1, 16'd300,   16'd300,   32'd90000};

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        res0_ready = 1'b0; res1_ready = 1'b0;
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {30'b0, res1_valid, res0_valid}, 32'd0);
        check("rst_data0", res0_data, 32'd0);
        check("rst_data1", res1_data, 32'd0);
        check("rst_gnt", {31'b0, gnt_id}, 32'd0);

        // First edge after release accepts; both valid -> requester 0 in either mode.
        rst_n = 1'b1;
        req1_valid = 1'b1; req1_a = 16'd3; req1_b = 16'd3;
        req0_valid = 1'b1; req0_a = 16'd12; req0_b = 16'd10;
        res0_ready = 1'b1;
        #1;
        check("first_ready", {30'b0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("first_busy", {31'b0, busy}, 32'd1);
        tick();
        check("first_valid", {30'b0, res1_valid, res0_valid}, 32'd1);
        check("first_data", res0_data, 32'd120);
        tick();
        check("first_idle", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Contention; last served was requester 1, so round-robin starts at 0.
        req0_valid = 1'b1; req0_a = 16'd5;   req0_b = 16'd15;
        req1_valid = 1'b1; req1_a = 16'd250; req1_b = 16'd11;
        res0_ready = 1'b1; res1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef MUL_RR_EN
            exp_id = k[0];
`else
            exp_id = 1'b0;
`endif
            #1;
            check("cont_ready", {30'b0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
            tick();
            check("cont_gnt", {31'b0, gnt_id}, {31'b0, exp_id});
            tick();
            check("cont_data", exp_id ? res1_data : res0_data, exp_id ? 32'd2750 : 32'd75);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("cont_idle", {31'b0, busy}, 32'd0);

        // Valid withdrawn before any edge: nothing happens.
        tick();
        req0_valid = 1'b1; req0_a = 16'd9; req0_b = 16'd9;
        #2;
        req0_valid = 1'b0;
        tick();
        check("drop_busy", {31'b0, busy}, 32'd0);
        check("drop_valid", {30'b0, res1_valid, res0_valid}, 32'd0);

        // Backpressure with a competing req1 and a stray non-owner res ready.
        res0_ready = 1'b0; res1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 16'd5526; req0_b = 16'd1660;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 16'd2; req1_b = 16'd2;
        tick();
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", {30'b0, res1_valid, res0_valid}, 32'd1);
            check("bp_data", res0_data, 32'd9173160);
            check("bp_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
            check("bp_busy", {31'b0, busy}, 32'd1);
            tick();
        end
        res0_ready = 1'b1;
        req1_valid = 1'b0;
        tick();
        check("bp_done_busy", {31'b0, busy}, 32'd0);
        check("bp_done_valid", {30'b0, res1_valid, res0_valid}, 32'd0);

        // Reset during MUL discards the transaction.
        req1_valid = 1'b1; req1_a = 16'd126; req1_b = 16'd211;
        tick();
        req1_valid = 1'b0;
        check("rmid_busy_pre", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmid_busy", {31'b0, busy}, 32'd0);
        check("rmid_gnt", {31'b0, gnt_id}, 32'd0);
        check("rmid_valid", {30'b0, res1_valid, res0_valid}, 32'd0);
        check("rmid_data1", res1_data, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rpost_valid", {30'b0, res1_valid, res0_valid}, 32'd0);
            check("rpost_busy", {31'b0, busy}, 32'd0);
        end
        do_txn(1'b0, 16'd7, 16'd9, 32'd63);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
